mem_access_ctrl: RTL and testbench

- Initiator side of the byte-wide main-memory interface (`mem_vis_addr`, `mem_vis_signal`, `writen_data`, `mem_data`).
- Accepts byte/half/word load and store requests from the cache/CPU side.
- Serialises each request into little-endian single-byte memory accesses, assembles load bytes into a LEN-bit result, and returns a one-cycle response pulse.

---
 rtl/mem_access_ctrl_if.sv | 29 ++
 rtl/mem_access_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Request/response bundle between the cache/CPU side and the memory access controller.
// The requester drives master; the controller sits on slave.
interface mem_access_ctrl_if #(
    parameter int ADDR_WIDTH = 17,
    parameter int LEN        = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic                  req_inst;
    logic [1:0]            req_size;
    logic                  req_sign;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [LEN-1:0]        req_wdata;
    logic                  resp_valid;
    logic [LEN-1:0]        resp_rdata;

    modport master (
        output req_valid, req_we, req_inst, req_size,
        output req_sign, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_inst, req_size,
        input  req_sign, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Serialises byte/half/word loads and stores into little-endian byte accesses
// on the byte-wide main-memory bus and returns a one-cycle response pulse.
module mem_access_ctrl #(
    parameter int ADDR_WIDTH = 17,
    parameter int LEN        = 32,
    parameter int BYTE_SIZE  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_access_ctrl_if.slave      req,
    output logic [ADDR_WIDTH-1:0] mem_vis_addr,
    output logic [1:0]            mem_vis_signal,
    output logic [BYTE_SIZE-1:0]  writen_data,
    input  logic [BYTE_SIZE-1:0]  mem_data
);
    localparam logic [1:0] MEM_IDLE      = 2'b00;
    localparam logic [1:0] MEM_READ_INST = 2'b01;
    localparam logic [1:0] MEM_READ_DATA = 2'b10;
    localparam logic [1:0] MEM_WRITE     = 2'b11;

    localparam int NB = LEN / BYTE_SIZE;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CW-1:0]         k_q, k_d;
    logic [CW-1:0]         last_q, last_d;
    logic [CW-1:0]         k_nx;
    logic                  we_q, we_d;
    logic                  sign_q, sign_d;
    logic [1:0]            size_q, size_d;
    logic [LEN-1:0]        wdata_q, wdata_d;
    logic [LEN-1:0]        buf_q, buf_d;
    logic [LEN-1:0]        asm_v;
    logic [BYTE_SIZE-1:0]  wbyte;
    logic [ADDR_WIDTH-1:0] vis_addr_d;
    logic [1:0]            sig_d;
    logic [BYTE_SIZE-1:0]  wr_d;
    logic                  rv_q, rv_d;
    logic [LEN-1:0]        rd_q, rd_d;

    function automatic logic [LEN-1:0] extend(
        input logic [LEN-1:0] v,
        input logic [1:0]     sz,
        input logic           sx
    );
        logic [LEN-1:0] r;
        r = v;
        unique case (sz)
            2'd0: r = {{(LEN-BYTE_SIZE){sx & v[BYTE_SIZE-1]}},
                       v[BYTE_SIZE-1:0]};
            2'd1: r = {{(LEN-2*BYTE_SIZE){sx & v[2*BYTE_SIZE-1]}},
                       v[2*BYTE_SIZE-1:0]};
            default: r = v;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (req.req_valid) state_d = S_ACCESS;
            S_ACCESS: if (k_q == last_q) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign k_nx = k_q + 1'b1;

    always_comb begin
        addr_d     = addr_q;
        k_d        = k_q;
        last_d     = last_q;
        we_d       = we_q;
        sign_d     = sign_q;
        size_d     = size_q;
        wdata_d    = wdata_q;
        buf_d      = buf_q;
        vis_addr_d = mem_vis_addr;
        sig_d      = MEM_IDLE;
        wr_d       = writen_data;
        rv_d       = 1'b0;
        rd_d       = rd_q;
        wbyte      = '0;
        asm_v      = buf_q;
        for (int i = 0; i < NB; i++) begin
            if (CW'(i) == k_nx) wbyte = wdata_q[i*BYTE_SIZE +: BYTE_SIZE];
            if (CW'(i) == k_q)  asm_v[i*BYTE_SIZE +: BYTE_SIZE] = mem_data;
        end
        unique case (state_q)
            S_IDLE: begin
                if (req.req_valid) begin
                    addr_d     = req.req_addr;
                    k_d        = '0;
                    we_d       = req.req_we;
                    sign_d     = req.req_sign;
                    size_d     = req.req_size;
                    wdata_d    = req.req_wdata;
                    buf_d      = '0;
                    vis_addr_d = req.req_addr;
                    unique case (req.req_size)
                        2'd0:    last_d = '0;
                        2'd1:    last_d = CW'(1);
                        default: last_d = CW'(NB - 1);
                    endcase
                    if (req.req_we) begin
                        sig_d = MEM_WRITE;
                        wr_d  = req.req_wdata[BYTE_SIZE-1:0];
                    end else begin
                        sig_d = req.req_inst ? MEM_READ_INST : MEM_READ_DATA;
                    end
                end
            end
            S_ACCESS: begin
                if (!we_q) buf_d = asm_v;
                if (k_q == last_q) begin
                    rv_d = 1'b1;
                    // the final byte arrives this cycle, so extend the merged view
                    if (!we_q) rd_d = extend(asm_v, size_q, sign_q);
                end else begin
                    k_d        = k_nx;
                    vis_addr_d = addr_q + ADDR_WIDTH'(k_nx);
                    sig_d      = mem_vis_signal;
                    if (we_q) wr_d = wbyte;
                end
            end
            S_DONE: begin
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q         <= '0;
            k_q            <= '0;
            last_q         <= '0;
            we_q           <= 1'b0;
            sign_q         <= 1'b0;
            size_q         <= '0;
            wdata_q        <= '0;
            buf_q          <= '0;
            mem_vis_addr   <= '0;
            mem_vis_signal <= MEM_IDLE;
            writen_data    <= '0;
            rv_q           <= 1'b0;
            rd_q           <= '0;
        end else begin
            addr_q         <= addr_d;
            k_q            <= k_d;
            last_q         <= last_d;
            we_q           <= we_d;
            sign_q         <= sign_d;
            size_q         <= size_d;
            wdata_q        <= wdata_d;
            buf_q          <= buf_d;
            mem_vis_addr   <= vis_addr_d;
            mem_vis_signal <= sig_d;
            writen_data    <= wr_d;
            rv_q           <= rv_d;
            rd_q           <= rd_d;
        end
    end

    assign req.req_ready  = (state_q == S_IDLE);
    assign req.resp_valid = rv_q;
    assign req.resp_rdata = rd_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: byte-wide memory model on the bus side,
// directed scenarios plus random traffic checked against a reference memory.
module tb_mem_access_ctrl;
    localparam int AW    = 17;
    localparam int LEN   = 32;
    localparam int MSIZE = 1 << AW;

    localparam logic [1:0] SIG_IDLE = 2'b00;
    localparam logic [1:0] SIG_RI   = 2'b01;
    localparam logic [1:0] SIG_RD   = 2'b10;
    localparam logic [1:0] SIG_WR   = 2'b11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] mem_vis_addr;
    logic [1:0]    mem_vis_signal;
    logic [7:0]    writen_data;
    logic [7:0]    mem_data;

    mem_access_ctrl_if #(.ADDR_WIDTH(AW), .LEN(LEN)) bus ();

    mem_access_ctrl #(
        .ADDR_WIDTH(AW),
        .LEN(LEN),
        .BYTE_SIZE(8)
    ) u_dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(bus),
        .mem_vis_addr(mem_vis_addr),
        .mem_vis_signal(mem_vis_signal),
        .writen_data(writen_data),
        .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    logic [7:0]    mem [MSIZE] = '{default: 8'h00};
    logic [7:0]    ref_mem [MSIZE] = '{default: 8'h00};
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [7:0]    pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (mem_vis_signal == SIG_WR) mem[mem_vis_addr] <= writen_data;
    end

    assign mem_data = (mem_vis_signal == SIG_RI || mem_vis_signal == SIG_RD)
                      ? mem[mem_vis_addr] : 8'h00;

    int resp_cnt = 0;
    always @(posedge clk) if (bus.resp_valid) resp_cnt++;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] last_load = '0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // called at a negedge with the DUT idle; returns at a negedge
    task automatic preload(input logic [AW-1:0] a, input logic [7:0] v);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = v;
        ref_mem[a] = v;
        @(posedge clk);
        #1 pre_we = 1'b0;
        @(negedge clk);
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [AW-1:0] wrap(input logic [AW-1:0] a, input int k);
        return AW'((int'(a) + k) % MSIZE);
    endfunction

    function automatic logic [31:0] ref_load(input logic [AW-1:0] a,
                                             input logic [1:0] size,
                                             input bit sgn);
        int n;
        logic [31:0] v;
        logic [31:0] mask;
        n = nbytes(size);
        v = '0;
        for (int i = 0; i < n; i++)
            v = v | (32'(ref_mem[wrap(a, i)]) << (8 * i));
        if (n < 4) begin
            mask = (32'h1 << (8 * n)) - 32'h1;
            if (sgn && v[8*n-1]) v = v | ~mask;
        end
        return v;
    endfunction

    logic          nxt_we, nxt_inst, nxt_sign;
    logic [1:0]    nxt_size;
    logic [AW-1:0] nxt_addr;
    logic [31:0]   nxt_wdata;

    task automatic do_req(input bit we, input bit inst, input logic [1:0] size,
                          input bit sgn, input logic [AW-1:0] a,
                          input logic [31:0] wd, input bit hold);
        int n;
        int w;
        logic [1:0]  esig;
        logic [31:0] exp_rd;
        n = nbytes(size);
        esig = we ? SIG_WR : (inst ? SIG_RI : SIG_RD);
        exp_rd = we ? last_load : ref_load(a, size, sgn);
        bus.req_we    = we;
        bus.req_inst  = inst;
        bus.req_size  = size;
        bus.req_sign  = sgn;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        w = 0;
        while (!bus.req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("ready", bus.req_ready, 1);
        check("idle_resp", bus.resp_valid, 0);
        check("idle_sig", mem_vis_signal, SIG_IDLE);
        @(posedge clk);
        #1;
        if (hold) begin
            bus.req_we    = nxt_we;
            bus.req_inst  = nxt_inst;
            bus.req_size  = nxt_size;
            bus.req_sign  = nxt_sign;
            bus.req_addr  = nxt_addr;
            bus.req_wdata = nxt_wdata;
        end else begin
            bus.req_valid = 1'b0;
        end
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("acc_addr", mem_vis_addr, wrap(a, k));
            check("acc_sig", mem_vis_signal, esig);
            check("acc_ready", bus.req_ready, 0);
            check("acc_resp", bus.resp_valid, 0);
            if (we) check("acc_wdata", writen_data, wd[8*k +: 8]);
        end
        @(negedge clk);
        check("done_resp", bus.resp_valid, 1);
        check("done_sig", mem_vis_signal, SIG_IDLE);
        check("done_ready", bus.req_ready, 0);
        check("done_rdata", bus.resp_rdata, exp_rd);
        if (we) begin
            for (int k = 0; k < n; k++) ref_mem[wrap(a, k)] = wd[8*k +: 8];
        end else begin
            last_load = exp_rd;
        end
    endtask

    initial begin
        int c0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_inst  = 1'b0;
        bus.req_size  = 2'd0;
        bus.req_sign  = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        #12;
        check("rst_ready", bus.req_ready, 1);
        check("rst_resp", bus.resp_valid, 0);
        check("rst_rdata", bus.resp_rdata, 0);
        check("rst_addr", mem_vis_addr, 0);
        check("rst_sig", mem_vis_signal, SIG_IDLE);
        check("rst_wd", writen_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        preload(17'h100, 8'h78);
        preload(17'h101, 8'h56);
        preload(17'h102, 8'h34);
        preload(17'h103, 8'h12);
        do_req(0, 0, 2'd2, 0, 17'h100, 0, 0);
        check("word_ld", bus.resp_rdata, 32'h12345678);

        preload(17'h1FFFF, 8'h80);
        do_req(0, 0, 2'd0, 1, 17'h1FFFF, 0, 0);
        check("byte_sx", bus.resp_rdata, 32'hFFFFFF80);
        do_req(0, 0, 2'd0, 0, 17'h1FFFF, 0, 0);
        check("byte_zx", bus.resp_rdata, 32'h00000080);

        @(negedge clk);
        preload(17'h00000, 8'hFF);
        do_req(0, 0, 2'd1, 0, 17'h1FFFF, 0, 0);
        check("half_wrap", bus.resp_rdata, 32'h0000FF80);

        do_req(1, 0, 2'd2, 0, 17'h200, 32'hDEADBEEF, 0);
        @(negedge clk);
        check("st_m0", mem[17'h200], 8'hEF);
        check("st_m1", mem[17'h201], 8'hBE);
        check("st_m2", mem[17'h202], 8'hAD);
        check("st_m3", mem[17'h203], 8'hDE);
        check("st_keep_rd", bus.resp_rdata, 32'h0000FF80);
        do_req(0, 0, 2'd2, 0, 17'h200, 0, 0);
        check("st_readback", bus.resp_rdata, 32'hDEADBEEF);

        @(negedge clk);
        c0 = resp_cnt;
        nxt_we    = 1'b0;
        nxt_inst  = 1'b1;
        nxt_size  = 2'd1;
        nxt_sign  = 1'b1;
        nxt_addr  = 17'h101;
        nxt_wdata = '0;
        do_req(0, 1, 2'd2, 0, 17'h100, 0, 1);
        do_req(0, 1, 2'd1, 1, 17'h101, 0, 0);
        check("b2b_half", bus.resp_rdata, 32'h00003456);
        @(negedge clk);
        check("b2b_pulses", resp_cnt - c0, 2);

        bus.req_we    = 1'b1;
        bus.req_inst  = 1'b0;
        bus.req_size  = 2'd2;
        bus.req_sign  = 1'b0;
        bus.req_addr  = 17'h300;
        bus.req_wdata = 32'h11223344;
        bus.req_valid = 1'b1;
        check("ab_ready", bus.req_ready, 1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        c0 = resp_cnt;
        #1;
        check("ab_sig", mem_vis_signal, SIG_IDLE);
        check("ab_ready_rst", bus.req_ready, 1);
        check("ab_resp", bus.resp_valid, 0);
        check("ab_addr", mem_vis_addr, 0);
        check("ab_rdata", bus.resp_rdata, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("ab_sig_hold", mem_vis_signal, SIG_IDLE);
        end
        rst_n = 1'b1;
        check("ab_m0", mem[17'h300], 8'h44);
        check("ab_m1", mem[17'h301], 8'h33);
        check("ab_m2", mem[17'h302], 8'h00);
        check("ab_m3", mem[17'h303], 8'h00);
        check("ab_nopulse", resp_cnt - c0, 0);
        ref_mem[17'h300] = 8'h44;
        ref_mem[17'h301] = 8'h33;
        last_load = '0;
        do_req(0, 0, 2'd2, 0, 17'h300, 0, 0);
        check("ab_after", bus.resp_rdata, 32'h00003344);

        for (int t = 0; t < 200; t++) begin
            logic [AW-1:0] a;
            if ($urandom_range(0, 1) == 0)
                a = AW'(17'h1FFFC + $urandom_range(0, 7));
            else
                a = AW'(17'h400 + $urandom_range(0, 31));
            do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   a, $urandom, 0);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
